// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says game controller:
// FSM encodings, 2-bit state codes, pad colours and LFSR setup.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_IN,
    S_RELEASE,
    S_WIN,
    S_LOSE
  } fsm_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GAME = 2'b01;
  localparam logic [1:0] ST_USER = 2'b10;
  localparam logic [1:0] ST_END  = 2'b11;

  localparam logic [3:0] COLOR_NONE = 4'b0000;
  localparam logic [3:0] COLOR_KEY0 = 4'b0001;
  localparam logic [3:0] COLOR_KEY1 = 4'b0010;
  localparam logic [3:0] COLOR_KEY2 = 4'b0100;
  localparam logic [3:0] COLOR_KEY3 = 4'b1000;
  localparam logic [3:0] COLOR_ALL  = 4'b1111;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [3:0] idx2color(input logic [1:0] i);
    logic [3:0] c;
    unique case (i)
      2'd0: c = COLOR_KEY0;
      2'd1: c = COLOR_KEY1;
      2'd2: c = COLOR_KEY2;
      default: c = COLOR_KEY3;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] state_code(input fsm_t s);
    logic [1:0] c;
    unique case (s)
      S_IDLE: c = ST_IDLE;
      S_ADD, S_SHOW_ON, S_SHOW_OFF: c = ST_GAME;
      S_WAIT_IN, S_RELEASE: c = ST_USER;
      default: c = ST_END;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] clamp_level(input logic [2:0] l);
    return (l == 3'd0 || l > 3'd5) ? 3'd1 : l;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (never zero from a non-zero seed).
// Ports: clk, rst_n (async low), en, q[15:0].
module lfsr16
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {^(q & LFSR_TAPS), q[15:1]};
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game control: sequence build, paced playback, key check.
// Ports: CLOCK_50, reset(n), start, level, key(n) -> state, color, level_q, score, win.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int STEP_CYCLES    = 25_000_000,
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [3:0] key,
  output logic [1:0] state,
  output logic [3:0] color,
  output logic [2:0] level_q,
  output logic [4:0] score,
  output logic       win
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [4:0] SCORE_MAX = 5'(MAX_LEN);
  localparam logic [31:0] STEP = 32'(STEP_CYCLES);
  localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

  fsm_t fsm, fsm_n;
  logic [LW-1:0] len, len_n;
  logic [LW-1:0] idx, idx_n;
  logic [31:0] timer, timer_n;
  logic [4:0] score_n;
  logic [2:0] level_n;
  logic win_n;
  logic seq_we;
  logic [3:0] color_n;
  logic [1:0] seq [MAX_LEN];

  logic [3:0] k_meta, k_sync, k_prev;
  logic s_meta, s_sync, s_prev;
  logic [3:0] press;
  logic start_edge;
  logic [15:0] lfsr;
  logic [31:0] on_time, gap_time;
  logic [3:0] cur_color;
  logic unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (CLOCK_50),
    .rst_n(reset),
    .en   (1'b1),
    .q    (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:2];
  assign press = k_prev & ~k_sync;
  assign start_edge = s_sync & ~s_prev;
  assign on_time = STEP >> (level_q - 3'd1);
  assign gap_time = on_time >> 1;
  assign cur_color = idx2color(seq[idx[IW-1:0]]);

  always_comb begin
    fsm_n = fsm;
    len_n = len;
    idx_n = idx;
    timer_n = timer;
    score_n = score;
    level_n = level_q;
    win_n = win;
    seq_we = 1'b0;
    color_n = COLOR_NONE;
    unique case (fsm)
      S_IDLE, S_WIN, S_LOSE: begin
        if (fsm == S_WIN) color_n = COLOR_ALL;
        if (start_edge) begin
          level_n = clamp_level(level);
          score_n = '0;
          len_n = '0;
          win_n = 1'b0;
          fsm_n = S_ADD;
        end
      end
      S_ADD: begin
        seq_we = 1'b1;
        len_n = len + ONE;
        idx_n = '0;
        timer_n = '0;
        fsm_n = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        color_n = cur_color;
        timer_n = timer + 32'd1;
        // Each show phase lasts at least one cycle even if its time is 0.
        if (timer + 32'd1 >= on_time) begin
          timer_n = '0;
          fsm_n = S_SHOW_OFF;
        end
      end
      S_SHOW_OFF: begin
        timer_n = timer + 32'd1;
        if (timer + 32'd1 >= gap_time) begin
          timer_n = '0;
          if (idx + ONE == len) begin
            idx_n = '0;
            fsm_n = S_WAIT_IN;
          end else begin
            idx_n = idx + ONE;
            fsm_n = S_SHOW_ON;
          end
        end
      end
      S_WAIT_IN: begin
        color_n = ~k_sync;
        if ($countones(press) > 1) begin
          fsm_n = S_LOSE;
        end else if (press != 4'b0000) begin
          fsm_n = (press == cur_color) ? S_RELEASE : S_LOSE;
        end else if (timer + 32'd1 >= TIMEOUT) begin
          fsm_n = S_LOSE;
        end else begin
          timer_n = timer + 32'd1;
        end
        if (fsm_n == S_LOSE) win_n = 1'b0;
      end
      S_RELEASE: begin
        color_n = ~k_sync;
        if (&k_sync) begin
          timer_n = '0;
          if (idx + ONE < len) begin
            idx_n = idx + ONE;
            fsm_n = S_WAIT_IN;
          end else begin
            idx_n = '0;
            if (score < SCORE_MAX) score_n = score + 5'd1;
            if (len == LEN_MAX) begin
              win_n = 1'b1;
              fsm_n = S_WIN;
            end else begin
              fsm_n = S_ADD;
            end
          end
        end
      end
      default: fsm_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      fsm <= S_IDLE;
      len <= '0;
      idx <= '0;
      timer <= '0;
      score <= '0;
      level_q <= 3'd1;
      win <= 1'b0;
      state <= ST_IDLE;
      color <= COLOR_NONE;
      k_meta <= 4'hF;
      k_sync <= 4'hF;
      k_prev <= 4'hF;
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seq[i] <= 2'b00;
    end else begin
      fsm <= fsm_n;
      len <= len_n;
      idx <= idx_n;
      timer <= timer_n;
      score <= score_n;
      level_q <= level_n;
      win <= win_n;
      state <= state_code(fsm);
      color <= color_n;
      k_meta <= key;
      k_sync <= k_meta;
      k_prev <= k_sync;
      s_meta <= start;
      s_sync <= s_meta;
      s_prev <= s_sync;
      if (seq_we) seq[len[IW-1:0]] <= lfsr[1:0];
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer with a reference model
// (LFSR-by-step-count, sequence queue, pacing from level).
module tb_simon_sequencer;

  localparam int STEP = 8;
  localparam int MAXL = 3;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [2:0] level = 3'd1;
  logic [3:0] key = 4'hF;
  logic [1:0] state;
  logic [3:0] color;
  logic [2:0] level_q;
  logic [4:0] score;
  logic win;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [1:0] exp_seq[$];

  simon_sequencer #(
    .STEP_CYCLES(STEP),
    .MAX_LEN(MAXL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .start(start),
    .level(level),
    .key(key),
    .state(state),
    .color(color),
    .level_q(level_q),
    .score(score),
    .win(win)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release = LFSR steps taken.
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++)
      v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    return v;
  endfunction

  function automatic logic [3:0] pad(input logic [1:0] e);
    return 4'(1 << e);
  endfunction

  function automatic int eff_level(input logic [2:0] l);
    return (l == 0 || l > 5) ? 1 : int'(l);
  endfunction

  function automatic logic [2:0] rand_level();
    logic [2:0] opts [6];
    opts = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    return opts[$urandom_range(0, 5)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] want,
                            input int budget,
                            output int n);
    n = 0;
    while (state !== want && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic press(input logic [3:0] pat, input int hold);
    key = pat;
    repeat (hold) tick();
    key = 4'hF;
  endtask

  task automatic start_game(input logic [2:0] lv);
    int n;
    level = lv;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    exp_seq.delete();
    wait_state(2'b01, 20, n);
    checks++;
    if (state !== 2'b01 || score !== 5'd0 || win !== 1'b0) begin
      failures++;
      $display("FAIL game_start: state=%b score=%0d win=%b want 01/0/0",
               state, score, win);
    end
    checks++;
    if (level_q !== 3'(eff_level(lv))) begin
      failures++;
      $display("FAIL level_latch: level_q=%0d want %0d",
               level_q, eff_level(lv));
    end
  endtask

  // Called on the first sample showing state 01 of a round.
  task automatic run_playback(input int on_t, input int gap_t,
                              input bit poke);
    logic [15:0] v;
    logic [3:0] want;
    int s;
    v = lfsr_after(cyc - 1);
    exp_seq.push_back(v[1:0]);
    checks++;
    if (state !== 2'b01 || color !== 4'h0) begin
      failures++;
      $display("FAIL add_slot: state=%b color=%b want 01/0000",
               state, color);
    end
    s = 0;
    foreach (exp_seq[i]) begin
      for (int j = 0; j < on_t + gap_t; j++) begin
        tick();
        s++;
        if (poke && s == 2) begin
          key = 4'($urandom_range(0, 14));
          start = 1'b1;
        end
        if (poke && s == 5) begin
          key = 4'hF;
          start = 1'b0;
        end
        want = (j < on_t) ? pad(exp_seq[i]) : 4'h0;
        checks++;
        if (state !== 2'b01 || color !== want) begin
          failures++;
          $display("FAIL playback[%0d.%0d]: state=%b color=%b want 01/%b",
                   i, j, state, color, want);
        end
      end
    end
    tick();
    checks++;
    if (state !== 2'b10 || color !== 4'h0) begin
      failures++;
      $display("FAIL enter_user: state=%b color=%b want 10/0000",
               state, color);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({state, color, level_q, score, win} !==
        {2'b00, 4'h0, 3'd1, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: st=%b col=%b lq=%0d sc=%0d win=%b",
               state, color, level_q, score, win);
    end
    reset = 1'b1;
    tick();
    start_game(3'd2);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({state, color, level_q, score, win} !==
        {2'b00, 4'h0, 3'd1, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL midrun_reset: st=%b col=%b lq=%0d sc=%0d win=%b",
               state, color, level_q, score, win);
    end
    reset = 1'b1;
    wait_state(2'b01, 4, n);
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: state=%b want 00", state);
    end
  endtask

  task automatic test_level_pacing();
    start_game(3'd3);
    level = 3'd5;
    run_playback(2, 1, 1'b0);
    checks++;
    if (level_q !== 3'd3) begin
      failures++;
      $display("FAIL level_hold: level_q=%0d want 3", level_q);
    end
  endtask

  task automatic test_timeout();
    int n;
    wait_state(2'b11, 100, n);
    checks++;
    if (state !== 2'b11 || win !== 1'b0 || color !== 4'h0) begin
      failures++;
      $display("FAIL timeout_lose: state=%b win=%b color=%b",
               state, win, color);
    end
    checks++;
    if (n < TMO - 1 || n > TMO + 2) begin
      failures++;
      $display("FAIL timeout_len: waited %0d cycles want about %0d",
               n, TMO);
    end
  endtask

  task automatic test_win();
    logic [2:0] lv;
    int on_t, n;
    lv = rand_level();
    on_t = STEP >> (eff_level(lv) - 1);
    start_game(lv);
    for (int r = 1; r <= MAXL; r++) begin
      if (r > 1) wait_state(2'b01, 20, n);
      checks++;
      if (state !== 2'b01 || score !== 5'(r - 1)) begin
        failures++;
        $display("FAIL round_score[%0d]: state=%b score=%0d want 01/%0d",
                 r, state, score, r - 1);
      end
      run_playback(on_t, on_t / 2, 1'b0);
      foreach (exp_seq[i]) begin
        if (i > 0) repeat (4) tick();
        press(~pad(exp_seq[i]), 2);
      end
    end
    wait_state(2'b11, 20, n);
    checks++;
    if (state !== 2'b11 || win !== 1'b1 || color !== 4'hF ||
        score !== 5'(MAXL)) begin
      failures++;
      $display("FAIL win_end: st=%b win=%b col=%b score=%0d want 11/1/1111/%0d",
               state, win, color, score, MAXL);
    end
  endtask

  task automatic test_wrong_key();
    logic [2:0] lv;
    int on_t, n;
    lv = rand_level();
    on_t = STEP >> (eff_level(lv) - 1);
    start_game(lv);
    run_playback(on_t, on_t / 2, 1'b0);
    press(~pad(exp_seq[0]), 2);
    wait_state(2'b01, 20, n);
    run_playback(on_t, on_t / 2, 1'b0);
    press(~pad(exp_seq[0]), 2);
    repeat (4) tick();
    press(~pad(exp_seq[1] + 2'd1), 2);
    wait_state(2'b11, 20, n);
    checks++;
    if (state !== 2'b11 || win !== 1'b0 || color !== 4'h0 ||
        score !== 5'd1) begin
      failures++;
      $display("FAIL wrong_key: st=%b win=%b col=%b score=%0d want 11/0/0000/1",
               state, win, color, score);
    end
  endtask

  task automatic test_multi_press();
    logic [2:0] lv;
    int on_t, n;
    lv = rand_level();
    on_t = STEP >> (eff_level(lv) - 1);
    start_game(lv);
    run_playback(on_t, on_t / 2, 1'b0);
    press(4'b1010, 2);
    wait_state(2'b11, 20, n);
    checks++;
    if (state !== 2'b11 || win !== 1'b0 || color !== 4'h0) begin
      failures++;
      $display("FAIL multi_press: st=%b win=%b col=%b want 11/0/0000",
               state, win, color);
    end
  endtask

  task automatic test_hold_ignore();
    int n;
    start_game(3'd7);
    run_playback(8, 4, 1'b1);
    key = ~pad(exp_seq[0]);
    repeat (8) tick();
    checks++;
    if (state !== 2'b10 || score !== 5'd0) begin
      failures++;
      $display("FAIL hold_early: state=%b score=%0d want 10/0",
               state, score);
    end
    repeat (12) tick();
    checks++;
    if (state !== 2'b10 || score !== 5'd0) begin
      failures++;
      $display("FAIL hold_late: state=%b score=%0d want 10/0",
               state, score);
    end
    key = 4'hF;
    wait_state(2'b01, 20, n);
    checks++;
    if (state !== 2'b01 || score !== 5'd1) begin
      failures++;
      $display("FAIL after_release: state=%b score=%0d want 01/1",
               state, score);
    end
    run_playback(8, 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_level_pacing();
    test_timeout();
    test_win();
    test_wrong_key();
    test_multi_press();
    test_hold_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
